// File: rtl/bf_ctrl_pkg.sv
// Shared types and helpers for the butterfly-stage control block.
package bf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    WAIT  = 2'd2,
    EN    = 2'd3
  } bf_state_e;

  // Counter/index width for a range of n values; never narrower than 1 bit.
  function automatic int bf_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bf_beat_cnt.sv
// Small up/down counter with clear, load and terminal-count flags.
// tc_o flags the current value; tc_nxt_o flags the value the counter
// takes at the next edge, so callers can register "last beat" outputs.
module bf_beat_cnt #(
  parameter int             W    = 1,
  parameter bit             DOWN = 1'b0,
  parameter logic [W-1:0]   TC   = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o,
  output logic         tc_nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (ld_i) cnt_d = ld_val_i;
    else if (en_i) cnt_d = DOWN ? (cnt_q - W'(1)) : (cnt_q + W'(1));
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign tc_o     = (cnt_q == TC);
  assign tc_nxt_o = (cnt_d == TC);

endmodule

// File: rtl/bf_stage_ctrl.sv
// Butterfly-stage control: alert pulse, programmable wait, valid burst.
// One-deep request queue, sticky overflow flag, per-frame block counter.
// Every output comes straight from a flop.
module bf_stage_ctrl
  import bf_ctrl_pkg::*;
#(
  parameter int ALERT_DLY = 1,
  parameter int VALID_LEN = 1,
  parameter int NUM_BLK   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bf_en,
  input  logic                        err_clr,
  output logic                        alert,
  output logic                        valid,
  output logic [bf_w(VALID_LEN)-1:0]  valid_idx,
  output logic                        busy,
  output logic [bf_w(NUM_BLK)-1:0]    blk_idx,
  output logic                        frame_done,
  output logic                        err_ovf
);

  localparam int VIW = bf_w(VALID_LEN);
  localparam int BIW = bf_w(NUM_BLK);
  localparam int WCW = bf_w(ALERT_DLY);

  // WAIT lasts ALERT_DLY-1 cycles: load ALERT_DLY-2 and leave when it hits 0.
  localparam logic [WCW-1:0] WAIT_LD   = (ALERT_DLY >= 2) ? WCW'(ALERT_DLY - 2) : '0;
  localparam logic [VIW-1:0] BEAT_LAST = VIW'(VALID_LEN - 1);
  localparam logic [BIW-1:0] BLK_LAST  = BIW'(NUM_BLK - 1);

  bf_state_e      state_q, state_d;
  logic           pending_q, pending_d;
  logic           err_ovf_q, err_ovf_d;
  logic [BIW-1:0] blk_q, blk_d;
  logic           alert_q, valid_q, busy_q, frame_done_q, frame_done_d;
  logic           ovf_set, last_beat;

  logic           wait_tc, beat_tc, beat_tc_nxt;
  logic [WCW-1:0] wait_cnt_unused;
  logic           wait_tcn_unused;

  // Wait counter: loaded while in ALERT, counts down through WAIT.
  bf_beat_cnt #(.W(WCW), .DOWN(1'b1), .TC('0)) u_wait_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (1'b0),
    .ld_i     (state_q == ALERT),
    .ld_val_i (WAIT_LD),
    .en_i     (state_q == WAIT),
    .cnt_o    (wait_cnt_unused),
    .tc_o     (wait_tc),
    .tc_nxt_o (wait_tcn_unused)
  );

  // Beat counter: zero outside EN, steps once per beat, so it is valid_idx.
  bf_beat_cnt #(.W(VIW), .DOWN(1'b0), .TC(BEAT_LAST)) u_beat_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (!((state_q == EN) && !beat_tc)),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (1'b1),
    .cnt_o    (valid_idx),
    .tc_o     (beat_tc),
    .tc_nxt_o (beat_tc_nxt)
  );

  // Next-state, queue, overflow and block-index logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    blk_d     = blk_q;
    ovf_set   = 1'b0;
    last_beat = (state_q == EN) && beat_tc;

    unique case (state_q)
      IDLE:    if (bf_en) state_d = ALERT;
      ALERT:   state_d = (ALERT_DLY == 1) ? EN : WAIT;
      WAIT:    if (wait_tc) state_d = EN;
      EN:      if (beat_tc) state_d = (pending_q || bf_en) ? ALERT : IDLE;
      default: state_d = IDLE;
    endcase

    if (last_beat) begin
      // A request on the last beat is queued and consumed at once; when the
      // queue was already full it refills it instead of overflowing.
      pending_d = pending_q & bf_en;
      blk_d     = (blk_q == BLK_LAST) ? '0 : (blk_q + BIW'(1));
    end else if ((state_q != IDLE) && bf_en) begin
      if (pending_q) ovf_set   = 1'b1;
      else           pending_d = 1'b1;
    end

    // Set wins over clear.
    err_ovf_d    = ovf_set | (err_ovf_q & ~err_clr);
    frame_done_d = (state_d == EN) && beat_tc_nxt && (blk_d == BLK_LAST);
  end

  // State, queue and status registers, plus registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      blk_q        <= '0;
      alert_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      err_ovf_q    <= err_ovf_d;
      blk_q        <= blk_d;
      alert_q      <= (state_d == ALERT);
      valid_q      <= (state_d == EN);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  assign alert      = alert_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign blk_idx    = blk_q;
  assign frame_done = frame_done_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_bf_stage_ctrl.sv
// Bench for bf_stage_ctrl: four differently parameterised instances share
// one stimulus stream; each is compared every cycle against a timeline
// model (position within the current request, queue flag, sticky error).
module tb_bf_stage_ctrl;
  import bf_ctrl_pkg::*;

  localparam int ND = 4;
  // Instance g uses element [g]: (AD,VL,NB) = (1,1,8) (3,4,8) (1,4,1) (2,3,3).
  localparam logic [ND-1:0][7:0] AD_T = {8'd2, 8'd1, 8'd3, 8'd1};
  localparam logic [ND-1:0][7:0] VL_T = {8'd3, 8'd4, 8'd4, 8'd1};
  localparam logic [ND-1:0][7:0] NB_T = {8'd3, 8'd1, 8'd8, 8'd8};

  logic clk = 1'b0, rst = 1'b0, bf_en = 1'b0, err_clr = 1'b0;
  logic       alert_w[ND], valid_w[ND], busy_w[ND], fdone_w[ND], ovf_w[ND];
  logic [7:0] vidx_w[ND], blk_w[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int AD = int'(AD_T[g]);
    localparam int VL = int'(VL_T[g]);
    localparam int NB = int'(NB_T[g]);
    logic [bf_w(VL)-1:0] vi;
    logic [bf_w(NB)-1:0] bi;
    bf_stage_ctrl #(.ALERT_DLY(AD), .VALID_LEN(VL), .NUM_BLK(NB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bf_en      (bf_en),
      .err_clr    (err_clr),
      .alert      (alert_w[g]),
      .valid      (valid_w[g]),
      .valid_idx  (vi),
      .busy       (busy_w[g]),
      .blk_idx    (bi),
      .frame_done (fdone_w[g]),
      .err_ovf    (ovf_w[g])
    );
    assign vidx_w[g] = 8'(vi);
    assign blk_w[g]  = 8'(bi);
  end

  always #5 clk = ~clk;

  // Model: m_t is the cycle offset from the alert cycle of the active request.
  int    m_t[ND], m_blk[ND];
  bit    m_act[ND], m_pend[ND], m_ovf[ND];
  int    n_chk = 0, n_err = 0;
  string ph = "init";

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < ND; g++) begin
      m_t[g] = 0; m_blk[g] = 0; m_act[g] = 0; m_pend[g] = 0; m_ovf[g] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit clr);
    for (int g = 0; g < ND; g++) begin
      int ad, vl, nb;
      bit set_ovf;
      ad = int'(AD_T[g]); vl = int'(VL_T[g]); nb = int'(NB_T[g]);
      set_ovf = 0;
      if (!m_act[g]) begin
        if (en) begin m_act[g] = 1; m_t[g] = 0; end
      end else if (m_t[g] == ad + vl - 1) begin
        m_blk[g] = (m_blk[g] + 1) % nb;
        if (m_pend[g] || en) begin
          m_t[g] = 0;
          m_pend[g] = m_pend[g] && en;
        end else m_act[g] = 0;
      end else begin
        m_t[g]++;
        if (en) begin
          if (m_pend[g]) set_ovf = 1;
          else           m_pend[g] = 1;
        end
      end
      m_ovf[g] = set_ovf || (m_ovf[g] && !clr);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < ND; g++) begin
      int ad, vl, nb;
      bit vld;
      ad = int'(AD_T[g]); vl = int'(VL_T[g]); nb = int'(NB_T[g]);
      vld = m_act[g] && (m_t[g] >= ad);
      chk($sformatf("%s d%0d alert", ph, g), int'(alert_w[g]), int'(m_act[g] && m_t[g] == 0));
      chk($sformatf("%s d%0d valid", ph, g), int'(valid_w[g]), int'(vld));
      chk($sformatf("%s d%0d valid_idx", ph, g), int'(vidx_w[g]), vld ? m_t[g] - ad : 0);
      chk($sformatf("%s d%0d busy", ph, g), int'(busy_w[g]), int'(m_act[g]));
      chk($sformatf("%s d%0d blk_idx", ph, g), int'(blk_w[g]), m_blk[g]);
      chk($sformatf("%s d%0d frame_done", ph, g), int'(fdone_w[g]),
          int'(vld && m_t[g] == ad + vl - 1 && m_blk[g] == nb - 1));
      chk($sformatf("%s d%0d err_ovf", ph, g), int'(ovf_w[g]), int'(m_ovf[g]));
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit en, input bit clr);
    bf_en   = en;
    err_clr = clr;
    model_step(en, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int k;
    ph = "reset";
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    ph = "single";
    cycle(1, 0);
    repeat (12) cycle(0, 0);

    ph = "b2b";
    cycle(1, 0); cycle(0, 0); cycle(0, 0); cycle(1, 0);
    repeat (16) cycle(0, 0);

    ph = "ovf";
    cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(1, 0); cycle(1, 0);
    repeat (16) cycle(0, 0);
    cycle(0, 1);
    repeat (2) cycle(0, 0);

    ph = "frame";
    repeat (9) begin
      cycle(1, 0);
      repeat (9) cycle(0, 0);
    end

    ph = "rand";
    repeat (600) cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8);
    repeat (12) cycle(0, 1);

    ph = "held";
    repeat (40) cycle(1, 0);
    repeat (12) cycle(0, 1);

    ph = "rst_mid";
    cycle(1, 0);
    k = 0;
    while (!valid_w[1] && k < 40) begin
      cycle(0, 0);
      k++;
    end
    chk("rst_mid reach_en", int'(valid_w[1]), 1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    ph = "post_rst";
    cycle(1, 0);
    repeat (12) cycle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
